// File: rtl/wall_collision.sv
// wall_collision: once per frame, scans every wall against the player
// rectangle (one wall per clock) and reports the lowest-numbered hit.
// Each rising contact costs one life. game_over is sticky until reset.
//
// Ports:
//   pixel_clk   clock, rising edge
//   reset       asynchronous, active-high
//   frame_tick  single-cycle scan request (ignored while busy or over)
//   wall_x_bus  wall k left edge at [11k+10:11k]
//   wall_y_bus  wall k top edge at [11k+10:11k]
//   player_x/y  player left / top edge
//   busy        scan in progress
//   scan_done   one-cycle pulse when hit/hit_index/lives update
//   hit         result of the last completed scan
//   hit_index   lowest hit wall index of the last scan (0 if none)
//   lives       remaining lives
//   game_over   sticky, set once lives reach 0
module wall_collision #(
  parameter int WALL_NUM = 10,
  parameter int IDX_W    = 4,
  parameter int WALL_W   = 20,
  parameter int WALL_H   = 100,
  parameter int PLAYER_W = 16,
  parameter int PLAYER_H = 16,
  parameter int LIVES    = 3
) (
  input  logic                    pixel_clk,
  input  logic                    reset,
  input  logic                    frame_tick,
  input  logic [11*WALL_NUM-1:0]  wall_x_bus,
  input  logic [11*WALL_NUM-1:0]  wall_y_bus,
  input  logic [10:0]             player_x,
  input  logic [10:0]             player_y,
  output logic                    busy,
  output logic                    scan_done,
  output logic                    hit,
  output logic [IDX_W-1:0]        hit_index,
  output logic [1:0]              lives,
  output logic                    game_over
);

  typedef enum logic [1:0] {IDLE, SCAN, REPORT, OVER} state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              acc_hit_q, acc_hit_d;
  logic [IDX_W-1:0]  acc_idx_q, acc_idx_d;
  logic              hit_q, hit_d;
  logic [IDX_W-1:0]  hit_index_q, hit_index_d;
  logic [1:0]        lives_q, lives_d;
  logic              prev_hit_q, prev_hit_d;
  logic              busy_q, scan_done_q, game_over_q;
  logic              snap;

  // Shadow copies so motion during a scan cannot disturb it.
  logic [10:0] wx_q [WALL_NUM];
  logic [10:0] wy_q [WALL_NUM];
  logic [10:0] px_q, py_q;

  logic [11:0] px_e, py_e, wx_e, wy_e;
  logic        overlap;

  // 12-bit sums so edges near the 11-bit limit do not wrap.
  assign px_e = {1'b0, px_q};
  assign py_e = {1'b0, py_q};
  assign wx_e = {1'b0, wx_q[idx_q]};
  assign wy_e = {1'b0, wy_q[idx_q]};

  assign overlap = (px_e < wx_e + 12'(WALL_W))   && (wx_e < px_e + 12'(PLAYER_W)) &&
                   (py_e < wy_e + 12'(WALL_H))   && (wy_e < py_e + 12'(PLAYER_H));

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    acc_hit_d   = acc_hit_q;
    acc_idx_d   = acc_idx_q;
    hit_d       = hit_q;
    hit_index_d = hit_index_q;
    lives_d     = lives_q;
    prev_hit_d  = prev_hit_q;
    snap        = 1'b0;
    case (state_q)
      IDLE: begin
        if (frame_tick) begin
          snap      = 1'b1;
          idx_d     = '0;
          acc_hit_d = 1'b0;
          acc_idx_d = '0;
          state_d   = SCAN;
        end
      end
      SCAN: begin
        // First overlap wins; the scan order makes it the lowest index.
        if (overlap && !acc_hit_q) begin
          acc_hit_d = 1'b1;
          acc_idx_d = idx_q;
        end
        if (idx_q == IDX_W'(WALL_NUM - 1)) state_d = REPORT;
        else                               idx_d   = idx_q + IDX_W'(1);
      end
      REPORT: begin
        hit_d       = acc_hit_q;
        hit_index_d = acc_idx_q;
        // Only a rising contact costs a life; held contact is free.
        if (acc_hit_q && !prev_hit_q && (lives_q != 2'd0)) lives_d = lives_q - 2'd1;
        prev_hit_d  = acc_hit_q;
        state_d     = (lives_d == 2'd0) ? OVER : IDLE;
      end
      OVER: state_d = OVER;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      acc_hit_q   <= 1'b0;
      acc_idx_q   <= '0;
      hit_q       <= 1'b0;
      hit_index_q <= '0;
      lives_q     <= 2'(LIVES);
      prev_hit_q  <= 1'b0;
      busy_q      <= 1'b0;
      scan_done_q <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      acc_hit_q   <= acc_hit_d;
      acc_idx_q   <= acc_idx_d;
      hit_q       <= hit_d;
      hit_index_q <= hit_index_d;
      lives_q     <= lives_d;
      prev_hit_q  <= prev_hit_d;
      // Outputs registered from the next state so they line up with it.
      busy_q      <= (state_d == SCAN) || (state_d == REPORT);
      scan_done_q <= (state_q == REPORT);
      game_over_q <= (state_d == OVER);
    end
  end

  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      px_q <= '0;
      py_q <= '0;
      for (int k = 0; k < WALL_NUM; k++) begin
        wx_q[k] <= '0;
        wy_q[k] <= '0;
      end
    end else if (snap) begin
      px_q <= player_x;
      py_q <= player_y;
      for (int k = 0; k < WALL_NUM; k++) begin
        wx_q[k] <= wall_x_bus[11*k +: 11];
        wy_q[k] <= wall_y_bus[11*k +: 11];
      end
    end
  end

  assign busy      = busy_q;
  assign scan_done = scan_done_q;
  assign hit       = hit_q;
  assign hit_index = hit_index_q;
  assign lives     = lives_q;
  assign game_over = game_over_q;

endmodule

// File: tb/tb_wall_collision.sv
module tb_wall_collision;
  localparam int WALL_NUM = 10;
  localparam int IDX_W    = 4;
  localparam int WALL_W   = 20;
  localparam int WALL_H   = 100;
  localparam int PLAYER_W = 16;
  localparam int PLAYER_H = 16;
  localparam int LIVES    = 3;

  logic                   pixel_clk = 1'b0;
  logic                   reset;
  logic                   frame_tick;
  logic [11*WALL_NUM-1:0] wall_x_bus, wall_y_bus;
  logic [10:0]            player_x, player_y;
  logic                   busy, scan_done, hit, game_over;
  logic [IDX_W-1:0]       hit_index;
  logic [1:0]             lives;

  wall_collision #(
    .WALL_NUM(WALL_NUM), .IDX_W(IDX_W), .WALL_W(WALL_W), .WALL_H(WALL_H),
    .PLAYER_W(PLAYER_W), .PLAYER_H(PLAYER_H), .LIVES(LIVES)
  ) dut (
    .pixel_clk(pixel_clk), .reset(reset), .frame_tick(frame_tick),
    .wall_x_bus(wall_x_bus), .wall_y_bus(wall_y_bus),
    .player_x(player_x), .player_y(player_y),
    .busy(busy), .scan_done(scan_done), .hit(hit), .hit_index(hit_index),
    .lives(lives), .game_over(game_over)
  );

  always #5 pixel_clk = ~pixel_clk;

  int tests = 0;
  int fails = 0;

  // Reference model state
  int m_wx [WALL_NUM];
  int m_wy [WALL_NUM];
  int m_px, m_py;
  int m_lives, m_prev, m_go, m_hit, m_idx;

  typedef struct {
    int ia; int xa; int ya;
    int ib; int xb; int yb;
    int px; int py;
    int eh; int ei; int el;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive_inputs();
    for (int k = 0; k < WALL_NUM; k++) begin
      wall_x_bus[11*k +: 11] = 11'(m_wx[k]);
      wall_y_bus[11*k +: 11] = 11'(m_wy[k]);
    end
    player_x = 11'(m_px);
    player_y = 11'(m_py);
  endtask

  task automatic far_walls();
    for (int k = 0; k < WALL_NUM; k++) begin
      m_wx[k] = 600;
      m_wy[k] = 0;
    end
  endtask

  function automatic bit rect_hit(input int k);
    return (m_px < m_wx[k] + WALL_W) && (m_wx[k] < m_px + PLAYER_W) &&
           (m_py < m_wy[k] + WALL_H) && (m_wy[k] < m_py + PLAYER_H);
  endfunction

  task automatic model_reset();
    m_lives = LIVES; m_prev = 0; m_go = 0; m_hit = 0; m_idx = 0;
  endtask

  task automatic model_scan();
    int h, ix;
    h = 0; ix = 0;
    for (int k = WALL_NUM - 1; k >= 0; k--)
      if (rect_hit(k)) begin h = 1; ix = k; end
    if (h == 1 && m_prev == 0 && m_lives > 0) m_lives--;
    m_prev = h; m_hit = h; m_idx = ix;
    if (m_lives == 0) m_go = 1;
  endtask

  task automatic check_state(input string tag);
    check({tag, "_hit"},   int'(hit),       m_hit);
    check({tag, "_idx"},   int'(hit_index), m_idx);
    check({tag, "_lives"}, int'(lives),     m_lives);
    check({tag, "_over"},  int'(game_over), m_go);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    frame_tick = 1'b0;
    @(negedge pixel_clk);
    @(negedge pixel_clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic run_scan(input bit jitter);
    int cnt, bad;
    bit was_go;
    drive_inputs();
    was_go = m_go[0];
    @(negedge pixel_clk) frame_tick = 1'b1;
    @(negedge pixel_clk) frame_tick = 1'b0;
    if (was_go) begin
      bad = 0;
      for (int i = 0; i < 15; i++) begin
        if (busy || scan_done) bad++;
        @(negedge pixel_clk);
      end
      check("over_ignore", bad, 0);
      check_state("over_hold");
      return;
    end
    model_scan();
    check("busy_rise", int'(busy), 1);
    check("done_early", int'(scan_done), 0);
    cnt = 0;
    while (!scan_done && cnt < 40) begin
      if (jitter) begin
        for (int k = 0; k < WALL_NUM; k++) begin
          wall_x_bus[11*k +: 11] = 11'($urandom_range(0, 400));
          wall_y_bus[11*k +: 11] = 11'($urandom_range(0, 400));
        end
        player_x = 11'($urandom_range(0, 400));
        player_y = 11'($urandom_range(0, 400));
      end
      @(negedge pixel_clk);
      cnt++;
    end
    check("latency", cnt, WALL_NUM + 1);
    check("busy_fall", int'(busy), 0);
    check_state("scan");
    @(negedge pixel_clk);
    check("done_width", int'(scan_done), 0);
  endtask

  initial begin
    int pulses;
    reset = 1'b1;
    frame_tick = 1'b0;
    far_walls();
    m_px = 100; m_py = 100;
    drive_inputs();

    vecs[0]  = '{3, 600, 0,   7, 600, 0,  100, 100, 0, 0, 3};
    vecs[1]  = '{3, 95, 50,   7, 95, 50,  100, 100, 1, 3, 2};
    vecs[2]  = '{3, 116, 50,  7, 600, 0,  100, 100, 0, 0, 3};
    vecs[3]  = '{3, 115, 50,  7, 600, 0,  100, 100, 1, 3, 2};
    vecs[4]  = '{3, 80, 50,   7, 600, 0,  100, 100, 0, 0, 3};
    vecs[5]  = '{3, 600, 0,   7, 95, 50,  100, 100, 1, 7, 2};
    vecs[6]  = '{3, 100, 116, 7, 600, 0,  100, 100, 0, 0, 3};
    vecs[7]  = '{3, 100, 115, 7, 600, 0,  100, 100, 1, 3, 2};
    vecs[8]  = '{0, 90, 90,   9, 90, 90,  100, 100, 1, 0, 2};
    vecs[9]  = '{9, 110, 110, 2, 600, 0,  100, 100, 1, 9, 2};
    vecs[10] = '{5, 2030, 1990, 6, 600, 0, 2040, 2000, 1, 5, 2};
    vecs[11] = '{3, 100, 0,   7, 600, 0,  100, 100, 0, 0, 3};
    vecs[12] = '{4, 2040, 1990, 6, 600, 0, 2047, 2000, 1, 4, 2};

    // Reset and idle
    apply_reset();
    for (int i = 0; i < 20; i++) begin
      @(negedge pixel_clk);
      check("idle_busy", int'(busy), 0);
      check("idle_done", int'(scan_done), 0);
      check("idle_hit", int'(hit), 0);
      check("idle_idx", int'(hit_index), 0);
      check("idle_lives", int'(lives), LIVES);
      check("idle_over", int'(game_over), 0);
    end

    // Directed table
    foreach (vecs[i]) begin
      apply_reset();
      far_walls();
      m_wx[vecs[i].ia] = vecs[i].xa; m_wy[vecs[i].ia] = vecs[i].ya;
      m_wx[vecs[i].ib] = vecs[i].xb; m_wy[vecs[i].ib] = vecs[i].yb;
      m_px = vecs[i].px; m_py = vecs[i].py;
      run_scan(1'b0);
      check($sformatf("tbl%0d_hit", i),   int'(hit),       vecs[i].eh);
      check($sformatf("tbl%0d_idx", i),   int'(hit_index), vecs[i].ei);
      check($sformatf("tbl%0d_lives", i), int'(lives),     vecs[i].el);
    end

    // Sustained contact, release, re-contact down to game over
    apply_reset();
    far_walls();
    m_wx[3] = 95; m_wy[3] = 50;
    m_px = 100; m_py = 100;
    for (int i = 0; i < 3; i++) begin
      run_scan(1'b0);
      check("hold_lives", int'(lives), 2);
    end
    m_px = 300; m_py = 300;
    run_scan(1'b0);
    check("clear_hit", int'(hit), 0);
    check("clear_lives", int'(lives), 2);
    m_px = 100; m_py = 100;
    run_scan(1'b0);
    check("recontact_lives", int'(lives), 1);
    m_px = 300; m_py = 300;
    run_scan(1'b0);
    m_px = 100; m_py = 100;
    run_scan(1'b0);
    check("final_lives", int'(lives), 0);
    check("final_over", int'(game_over), 1);
    run_scan(1'b0);
    check("over_busy", int'(busy), 0);
    check("over_hit_held", int'(hit), 1);
    check("over_idx_held", int'(hit_index), 3);

    // Reset 5 clocks into a scan
    apply_reset();
    far_walls();
    m_wx[3] = 95; m_wy[3] = 50;
    m_px = 100; m_py = 100;
    drive_inputs();
    @(negedge pixel_clk) frame_tick = 1'b1;
    @(negedge pixel_clk) frame_tick = 1'b0;
    repeat (4) @(negedge pixel_clk);
    check("pre_abort_busy", int'(busy), 1);
    reset = 1'b1;
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(scan_done), 0);
    check("abort_hit", int'(hit), 0);
    check("abort_idx", int'(hit_index), 0);
    check("abort_lives", int'(lives), LIVES);
    check("abort_over", int'(game_over), 0);
    @(negedge pixel_clk);
    reset = 1'b0;
    model_reset();
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge pixel_clk);
      if (scan_done) pulses++;
    end
    check("abort_no_done", pulses, 0);

    // Second tick 4 clocks after the first is dropped
    apply_reset();
    far_walls();
    m_px = 100; m_py = 100;
    drive_inputs();
    @(negedge pixel_clk) frame_tick = 1'b1;
    @(negedge pixel_clk) frame_tick = 1'b0;
    pulses = 0;
    for (int i = 0; i < 35; i++) begin
      frame_tick = (i == 3);
      @(negedge pixel_clk);
      if (scan_done) pulses++;
    end
    frame_tick = 1'b0;
    check("double_tick_pulses", pulses, 1);

    // Randomized scans with bus motion during each scan
    apply_reset();
    for (int n = 0; n < 60; n++) begin
      for (int k = 0; k < WALL_NUM; k++) begin
        m_wx[k] = $urandom_range(0, 400);
        m_wy[k] = $urandom_range(0, 400);
      end
      m_px = $urandom_range(0, 400);
      m_py = $urandom_range(0, 400);
      run_scan(1'b1);
      if (m_go == 1 && $urandom_range(0, 1) == 1) apply_reset();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
